// File: rtl/pulse_shift_out.sv
// pulse_shift_out: programmable pulse divider plus an independent
// parallel-load / serial-out shift register.
//
// Divider: the counter runs down while div_enable is high. When it reaches
// zero it reloads from divisor and emits a one-cycle pulse_out tick, so a
// tick occurs every divisor+1 enabled cycles. div_clear reloads the counter
// with InitialDivisor and takes priority over div_enable.
//
// Shift register: a parallel load takes priority over a shift. On a shift
// serial_in enters the vacated end. Reset fills the register with ones, so
// serial_out idles high.
//
// Optional build macro PULSE_SHIFT_OUT_MSB_FIRST_EN:
//   undefined (default): serial_out = sr[0], shift right, serial_in enters at the MSB.
//   defined:             serial_out = sr[Width-1], shift left, serial_in enters at the LSB.
// The divider behaves the same in both builds.
//
// rst is synchronous and active-high. It resets the whole block and
// overrides every other input.

module pulse_shift_out #(
    parameter int Width          = 11,
    parameter int DivWidth       = 3,
    parameter int InitialDivisor = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                div_clear,
    input  logic [DivWidth-1:0] divisor,
    input  logic                div_enable,
    output logic                pulse_out,
    input  logic                serial_in,
    input  logic [Width-1:0]    parallel_input,
    input  logic                parallel_load,
    input  logic                shift_enable,
    output logic                serial_out
);

    localparam logic [DivWidth-1:0] InitCnt = DivWidth'(InitialDivisor);
    localparam logic [DivWidth-1:0] CntZero = {DivWidth{1'b0}};
    localparam logic [DivWidth-1:0] CntOne  = {{(DivWidth-1){1'b0}}, 1'b1};
    localparam logic [Width-1:0]    SrIdle  = {Width{1'b1}};

    logic [DivWidth-1:0] cnt_q;
    logic [DivWidth-1:0] cnt_d;
    logic                pulse_q;
    logic                pulse_d;
    logic [Width-1:0]    sr_q;
    logic [Width-1:0]    sr_d;

    // Divider next state: clear wins, then reload-and-tick or count down while enabled.
    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (div_clear) begin
            cnt_d   = InitCnt;
            pulse_d = 1'b0;
        end else if (div_enable) begin
            if (cnt_q == CntZero) begin
                cnt_d   = divisor;
                pulse_d = 1'b1;
            end else begin
                cnt_d   = cnt_q - CntOne;
                pulse_d = 1'b0;
            end
        end else begin
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
        end
    end

    // Shift register next state: load beats shift, otherwise hold.
    always_comb begin
        sr_d = sr_q;
        if (parallel_load) begin
            sr_d = parallel_input;
        end else if (shift_enable) begin
`ifdef PULSE_SHIFT_OUT_MSB_FIRST_EN
            sr_d = {sr_q[Width-2:0], serial_in};
`else
            sr_d = {serial_in, sr_q[Width-1:1]};
`endif
        end else begin
            sr_d = sr_q;
        end
    end

    // State flops with synchronous reset that overrides all other inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= InitCnt;
            pulse_q <= 1'b0;
            sr_q    <= SrIdle;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            sr_q    <= sr_d;
        end
    end

    assign pulse_out = pulse_q;

`ifdef PULSE_SHIFT_OUT_MSB_FIRST_EN
    assign serial_out = sr_q[Width-1];
`else
    assign serial_out = sr_q[0];
`endif

endmodule

// File: tb/tb_pulse_shift_out.sv
// Directed testbench for pulse_shift_out (default LSB-first build,
// Width=11, DivWidth=3, InitialDivisor=7).
`timescale 1ns/1ps

module tb_pulse_shift_out;

    logic        clk;
    logic        rst;
    logic        div_clear;
    logic [2:0]  divisor;
    logic        div_enable;
    logic        pulse_out;
    logic        serial_in;
    logic [10:0] parallel_input;
    logic        parallel_load;
    logic        shift_enable;
    logic        serial_out;

    int vectors;
    int miscompares;

    pulse_shift_out #(
        .Width(11),
        .DivWidth(3),
        .InitialDivisor(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .div_clear(div_clear),
        .divisor(divisor),
        .div_enable(div_enable),
        .pulse_out(pulse_out),
        .serial_in(serial_in),
        .parallel_input(parallel_input),
        .parallel_load(parallel_load),
        .shift_enable(shift_enable),
        .serial_out(serial_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        div_enable     = 1'b1;
        divisor        = 3'd2;
        parallel_load  = 1'b1;
        parallel_input = 11'h000;
        shift_enable   = 1'b1;
        serial_in      = 1'b0;
        div_clear      = 1'b0;
        do_reset();
        parallel_load = 1'b0;
        shift_enable  = 1'b0;
        vectors++;
        if (pulse_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pulse: got %b want 0", pulse_out);
        end
        vectors++;
        if (serial_out !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_serial: got %b want 1", serial_out);
        end
        vectors++;
        if (dut.cnt_q !== 3'd7) begin
            miscompares++;
            $display("FAIL reset_cnt: got %0d want 7", dut.cnt_q);
        end
        vectors++;
        if (dut.sr_q !== 11'h7FF) begin
            miscompares++;
            $display("FAIL reset_sr: got %h want 7ff", dut.sr_q);
        end
    endtask

    // divisor=7: ticks at edges 8,16,24; shift_enable toggling must not disturb it
    task automatic test_divider_period();
        logic exp;
        divisor    = 3'd7;
        div_enable = 1'b1;
        div_clear  = 1'b0;
        serial_in  = 1'b1;
        do_reset();
        for (int e = 1; e <= 24; e++) begin
            shift_enable = e[0];
            tick();
            exp = ((e % 8) == 0);
            vectors++;
            if (pulse_out !== exp) begin
                miscompares++;
                $display("FAIL period_edge%0d: got %b want %b", e, pulse_out, exp);
            end
        end
        shift_enable = 1'b0;
    endtask

    task automatic test_divisor_zero();
        logic exp;
        divisor    = 3'd0;
        div_enable = 1'b1;
        div_clear  = 1'b0;
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            tick();
            exp = (e >= 8);
            vectors++;
            if (pulse_out !== exp) begin
                miscompares++;
                $display("FAIL div0_edge%0d: got %b want %b", e, pulse_out, exp);
            end
        end
        div_enable = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            vectors++;
            if (pulse_out !== 1'b0) begin
                miscompares++;
                $display("FAIL div0_paused%0d: got %b want 0", e, pulse_out);
            end
        end
        vectors++;
        if (dut.cnt_q !== 3'd0) begin
            miscompares++;
            $display("FAIL div0_cnt_held: got %0d want 0", dut.cnt_q);
        end
        div_enable = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            vectors++;
            if (pulse_out !== 1'b1) begin
                miscompares++;
                $display("FAIL div0_resume%0d: got %b want 1", e, pulse_out);
            end
        end
    endtask

    task automatic test_div_clear();
        logic exp;
        divisor    = 3'd7;
        div_enable = 1'b1;
        div_clear  = 1'b0;
        do_reset();
        for (int e = 1; e <= 4; e++) tick();
        vectors++;
        if (dut.cnt_q !== 3'd3) begin
            miscompares++;
            $display("FAIL clear_precnt: got %0d want 3", dut.cnt_q);
        end
        div_clear = 1'b1;
        tick();
        div_clear = 1'b0;
        vectors++;
        if (dut.cnt_q !== 3'd7 || pulse_out !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_apply: got cnt=%0d pulse=%b want cnt=7 pulse=0", dut.cnt_q, pulse_out);
        end
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = (e == 8);
            vectors++;
            if (pulse_out !== exp) begin
                miscompares++;
                $display("FAIL clear_edge%0d: got %b want %b", e, pulse_out, exp);
            end
        end
        div_enable = 1'b0;
    endtask

    // load 11'b11001010110 then shift ones in; output is the pattern LSB-first, then idle high
    task automatic test_shift_lsb();
        logic [10:0] pat;
        pat = 11'b11001010110;
        do_reset();
        parallel_input = pat;
        parallel_load  = 1'b1;
        tick();
        parallel_load = 1'b0;
        vectors++;
        if (serial_out !== 1'b0) begin
            miscompares++;
            $display("FAIL shift_bit0: got %b want 0", serial_out);
        end
        serial_in    = 1'b1;
        shift_enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            vectors++;
            if (i <= 10) begin
                if (serial_out !== pat[i]) begin
                    miscompares++;
                    $display("FAIL shift_bit%0d: got %b want %b", i, serial_out, pat[i]);
                end
            end else begin
                if (serial_out !== 1'b1) begin
                    miscompares++;
                    $display("FAIL shift_idle%0d: got %b want 1", i, serial_out);
                end
            end
        end
        shift_enable = 1'b0;
        vectors++;
        if (dut.sr_q !== 11'h7FF) begin
            miscompares++;
            $display("FAIL shift_refill: got %h want 7ff", dut.sr_q);
        end
    endtask

    task automatic test_load_priority();
        parallel_input = 11'h555;
        parallel_load  = 1'b1;
        shift_enable   = 1'b1;
        serial_in      = 1'b0;
        tick();
        parallel_load = 1'b0;
        shift_enable  = 1'b0;
        vectors++;
        if (serial_out !== 1'b1 || dut.sr_q !== 11'h555) begin
            miscompares++;
            $display("FAIL load_wins: got out=%b sr=%h want out=1 sr=555", serial_out, dut.sr_q);
        end
        parallel_input = 11'h000;
        for (int i = 0; i < 3; i++) tick();
        vectors++;
        if (dut.sr_q !== 11'h555) begin
            miscompares++;
            $display("FAIL hold: got %h want 555", dut.sr_q);
        end
        shift_enable = 1'b1;
        serial_in    = 1'b0;
        tick();
        shift_enable = 1'b0;
        vectors++;
        if (serial_out !== 1'b0 || dut.sr_q !== 11'h2AA) begin
            miscompares++;
            $display("FAIL one_shift: got out=%b sr=%h want out=0 sr=2aa", serial_out, dut.sr_q);
        end
    endtask

    task automatic test_reset_mid_shift();
        divisor    = 3'd7;
        div_enable = 1'b1;
        parallel_input = 11'h000;
        parallel_load  = 1'b1;
        tick();
        parallel_load = 1'b0;
        shift_enable  = 1'b1;
        serial_in     = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (serial_out !== 1'b0) begin
            miscompares++;
            $display("FAIL midshift_pre: got %b want 0", serial_out);
        end
        rst           = 1'b1;
        parallel_load = 1'b1;
        tick();
        rst           = 1'b0;
        parallel_load = 1'b0;
        shift_enable  = 1'b0;
        vectors++;
        if (serial_out !== 1'b1 || dut.sr_q !== 11'h7FF) begin
            miscompares++;
            $display("FAIL midshift_rst: got out=%b sr=%h want out=1 sr=7ff", serial_out, dut.sr_q);
        end
        vectors++;
        if (dut.cnt_q !== 3'd7 || pulse_out !== 1'b0) begin
            miscompares++;
            $display("FAIL midshift_div: got cnt=%0d pulse=%b want cnt=7 pulse=0", dut.cnt_q, pulse_out);
        end
        div_enable = 1'b0;
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b0;
        div_clear      = 1'b0;
        divisor        = 3'd7;
        div_enable     = 1'b0;
        serial_in      = 1'b1;
        parallel_input = 11'h000;
        parallel_load  = 1'b0;
        shift_enable   = 1'b0;
        tick();
        test_reset();
        test_divider_period();
        test_divisor_zero();
        test_div_clear();
        test_shift_lsb();
        test_load_priority();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
